// File: rtl/timer_digit_entry_if.sv
// Digit-entry bus: encoder inputs, control levels, and outputs toward the countdown timer.
// master drives the keys and controls; slave is the digit-entry controller.
interface timer_digit_entry_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);

  logic [3:0]              bcd;
  logic                    valid_data;
  logic                    start;
  logic                    clear;
  logic                    timer_done;
  logic                    enablen;
  logic                    loadn;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [CW-1:0]           digit_count;

  modport master (
    output bcd, valid_data, start, clear, timer_done,
    input  enablen, loadn, digits, digit_count
  );

  modport slave (
    input  bcd, valid_data, start, clear, timer_done,
    output enablen, loadn, digits, digit_count
  );
endinterface

// File: rtl/timer_digit_entry.sv
// Digit-entry controller: captures one BCD digit per key press into a shift register,
// pulses loadn to hand the value to the countdown timer, and disables the encoder while
// the timer runs.
// Optional: define TIMER_ENTRY_SEC_CLAMP_EN to clamp the seconds field to 59 at load.
module timer_digit_entry #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned LOAD_PULSE = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  timer_digit_entry_if.slave   bus
);
  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
  localparam int unsigned PW = (LOAD_PULSE < 1) ? 1 : $clog2(LOAD_PULSE + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StEntry = 2'd1;
  localparam logic [1:0] StLoad  = 2'd2;
  localparam logic [1:0] StRun   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] digits_q, digits_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          vd_q;
  logic          loadn_q, loadn_d;
  logic          enablen_q, enablen_d;
  logic          key_edge, key_ok;

  // One key per press: rising edge of the level strobe; codes above 9 are swallowed.
  assign key_edge = bus.valid_data & ~vd_q;
  assign key_ok   = key_edge && (bus.bcd <= 4'd9);

  // Next-state, digit shift register and load-pulse counter.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    pulse_d  = pulse_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.clear && key_ok) begin
          digits_d = {digits_q[DW-5:0], bus.bcd};
          count_d  = count_q + 1'b1;
          state_d  = StEntry;
        end
      end
      StEntry: begin
        if (bus.clear) begin
          digits_d = '0;
          count_d  = '0;
          state_d  = StIdle;
        end else if (bus.start) begin
          // A key arriving with start is dropped so the loaded value is what was shown.
          pulse_d = '0;
          state_d = StLoad;
`ifdef TIMER_ENTRY_SEC_CLAMP_EN
          if (digits_q[7:0] > 8'h59) digits_d[7:0] = 8'h59;
`endif
        end else if (key_ok) begin
          digits_d = {digits_q[DW-5:0], bus.bcd};
          if (count_q != CW'(NUM_DIGITS)) count_d = count_q + 1'b1;
        end
      end
      StLoad: begin
        // First cycle here only arms the counter; loadn is low while pulse is 1..LOAD_PULSE.
        if (pulse_q == PW'(LOAD_PULSE)) state_d = StRun;
        else pulse_d = pulse_q + 1'b1;
      end
      StRun: begin
        if (bus.clear || bus.timer_done) begin
          digits_d = '0;
          count_d  = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so loadn rise and enablen rise coincide.
  always_comb begin
    loadn_d   = !((state_d == StLoad) && (pulse_d != '0));
    enablen_d = (state_d == StRun);
  end

  // State registers; vd_q resets high so a key held through reset is not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      digits_q  <= '0;
      count_q   <= '0;
      pulse_q   <= '0;
      vd_q      <= 1'b1;
      loadn_q   <= 1'b1;
      enablen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      count_q   <= count_d;
      pulse_q   <= pulse_d;
      vd_q      <= bus.valid_data;
      loadn_q   <= loadn_d;
      enablen_q <= enablen_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_count = count_q;
  assign bus.loadn       = loadn_q;
  assign bus.enablen     = enablen_q;
endmodule

// File: tb/tb_timer_digit_entry.sv
// Self-checking bench for timer_digit_entry: scoreboard of expected output snapshots plus
// direct load-pulse measurements.
module tb_timer_digit_entry;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned LOAD_PULSE = 3;

  typedef struct {
    string       tag;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        loadn;
    logic        enablen;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  timer_digit_entry_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

  timer_digit_entry #(
    .NUM_DIGITS(NUM_DIGITS),
    .LOAD_PULSE(LOAD_PULSE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] d, input logic [2:0] c,
                         input logic l, input logic e);
    exp_t x;
    x.tag = tag; x.digits = d; x.count = c; x.loadn = l; x.enablen = e;
    sb.push_back(x);
  endtask

  // Pop every pending expectation and compare with the DUT as it stands now.
  task automatic sb_check();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check({x.tag, "_digits"}, 32'(bus.digits), 32'(x.digits));
      check({x.tag, "_count"}, 32'(bus.digit_count), 32'(x.count));
      check({x.tag, "_loadn"}, 32'(bus.loadn), 32'(x.loadn));
      check({x.tag, "_enablen"}, 32'(bus.enablen), 32'(x.enablen));
    end
  endtask

  task automatic press(input logic [3:0] d);
    bus.bcd = d;
    bus.valid_data = 1'b1;
    repeat (5) @(negedge clk);
    bus.valid_data = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Measure the loadn low window, the digits shown during it, and enablen when loadn rises.
  task automatic watch_load(output int lows, output logic [15:0] d_seen, output logic en_rise);
    lows = 0; d_seen = '1; en_rise = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.loadn == 1'b0) begin
        lows++;
        d_seen = bus.digits;
      end else if (lows > 0) begin
        en_rise = bus.enablen;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.loadn == 1'b0) lows++;
    end
  endtask

  int          lows;
  logic [15:0] d_seen;
  logic        en_rise;
  logic [15:0] clamp_exp;

  initial begin
    bus.bcd = '0; bus.valid_data = 1'b0; bus.start = 1'b0;
    bus.clear = 1'b0; bus.timer_done = 1'b0;
    repeat (2) @(negedge clk);
    sb_push("reset", 16'h0000, 3'd0, 1'b1, 1'b0);
    sb_check();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Digit entry, one shift per press.
    press(4'd1); sb_push("key1", 16'h0001, 3'd1, 1'b1, 1'b0); sb_check();
    press(4'd2); sb_push("key2", 16'h0012, 3'd2, 1'b1, 1'b0); sb_check();
    press(4'd3); sb_push("key3", 16'h0123, 3'd3, 1'b1, 1'b0); sb_check();
    press(4'd0); sb_push("key4", 16'h1230, 3'd4, 1'b1, 1'b0); sb_check();
    press(4'd7); sb_push("overflow", 16'h2307, 3'd4, 1'b1, 1'b0); sb_check();

    bus.clear = 1'b1; @(negedge clk); bus.clear = 1'b0;
    sb_push("clear_entry", 16'h0000, 3'd0, 1'b1, 1'b0); sb_check();

    press(4'hC); sb_push("invalid", 16'h0000, 3'd0, 1'b1, 1'b0); sb_check();

    // Load and run.
    press(4'd0); press(4'd1); press(4'd3); press(4'd0);
    sb_push("entry0130", 16'h0130, 3'd4, 1'b1, 1'b0); sb_check();
    pulse_start();
    watch_load(lows, d_seen, en_rise);
    check("load_width", lows, LOAD_PULSE);
    check("load_digits", 32'(d_seen), 32'h0130);
    check("run_enablen", 32'(en_rise), 32'd1);
    press(4'd5); sb_push("run_key", 16'h0130, 3'd4, 1'b1, 1'b1); sb_check();
    bus.timer_done = 1'b1; @(negedge clk); bus.timer_done = 1'b0;
    sb_push("done", 16'h0000, 3'd0, 1'b1, 1'b0); sb_check();

    // Start and key in the same cycle: key dropped.
    press(4'd4);
    bus.bcd = 4'd9; bus.valid_data = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    watch_load(lows, d_seen, en_rise);
    bus.valid_data = 1'b0;
    check("startkey_width", lows, LOAD_PULSE);
    check("startkey_digits", 32'(d_seen), 32'h0004);
    bus.clear = 1'b1; @(negedge clk); bus.clear = 1'b0;
    sb_push("clear_run", 16'h0000, 3'd0, 1'b1, 1'b0); sb_check();

    // Clear beats start.
    press(4'd8);
    bus.clear = 1'b1; bus.start = 1'b1; @(negedge clk);
    bus.clear = 1'b0; bus.start = 1'b0;
    sb_push("clear_start", 16'h0000, 3'd0, 1'b1, 1'b0); sb_check();
    count_low(8, lows);
    check("clear_start_noload", lows, 0);

    // Start in IDLE does nothing.
    pulse_start();
    count_low(8, lows);
    check("idle_start_noload", lows, 0);
    sb_push("idle_start", 16'h0000, 3'd0, 1'b1, 1'b0); sb_check();

    // Key held across reset release.
    press(4'd2);
    bus.bcd = 4'd6; bus.valid_data = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sb_push("held_reset", 16'h0000, 3'd0, 1'b1, 1'b0); sb_check();
    bus.valid_data = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during LOAD releases loadn without a clock edge.
    press(4'd2);
    pulse_start();
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.loadn == 1'b0) begin
        lows = 1;
        break;
      end
      @(negedge clk);
    end
    check("midload_seen", lows, 1);
    #1 rst_n = 1'b0;
    #1;
    sb_push("midload_reset", 16'h0000, 3'd0, 1'b1, 1'b0); sb_check();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Seconds clamp at load.
`ifdef TIMER_ENTRY_SEC_CLAMP_EN
    clamp_exp = 16'h0159;
`else
    clamp_exp = 16'h0175;
`endif
    press(4'd0); press(4'd1); press(4'd7); press(4'd5);
    sb_push("entry0175", 16'h0175, 3'd4, 1'b1, 1'b0); sb_check();
    pulse_start();
    watch_load(lows, d_seen, en_rise);
    check("clamp_width", lows, LOAD_PULSE);
    check("clamp_digits", 32'(d_seen), 32'(clamp_exp));
    bus.timer_done = 1'b1; @(negedge clk); bus.timer_done = 1'b0;
    sb_push("clamp_done", 16'h0000, 3'd0, 1'b1, 1'b0); sb_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/timer_digit_entry.md
# timer_digit_entry

Digit-entry controller for the timer input path. Consumes the BCD digit and `valid_data` strobe from the keyboard encoder, captures one digit per key press into a shift register of BCD digits (MM:SS order for the default four digits), and hands the assembled value to the countdown timer via an active-low load pulse. While the timer runs, it gates the encoder off through `enablen`.

## Interface
- `NUM_DIGITS`, 4: number of BCD digits held; must be ≥ 2.
- `LOAD_PULSE`, 1: number of cycles `loadn` is held low; must be ≥ 1.

- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `bcd`  in  4  digit from the encoder.
- `valid_data`  in  1  encoder strobe, level-high while a key is held.
- `start`  in  1  level, request to load the entered value into the timer.
- `clear`  in  1  level, discard entry or abort a run.
- `timer_done`  in  1  timer reached zero, level or pulse.
- `enablen`  out  1  registered encoder enable, active-low; 1 means the encoder is disabled.
- `loadn`  out  1  registered active-low load strobe to the timer.
- `digits`  out  4*NUM_DIGITS  entered value; `[3:0]` is the most recent digit and `[4*NUM_DIGITS-1 -: 4]` is the oldest.
- `digit_count`  out  $clog2(NUM_DIGITS+1)  digits captured, saturating at NUM_DIGITS.

## Operation
- **Key edge detection:** `vd_q` is a register copy of `valid_data`. A key is accepted when `valid_data`=1 and `vd_q`=0. Exactly one digit is taken per press, regardless of hold time.
- **Digit acceptance:** an accepted key with `bcd` > 9 is consumed but not stored.
- **Shift:** an accepted digit shifts in as `digits <= {digits[4*NUM_DIGITS-5:0], bcd}`. The oldest digit drops off once NUM_DIGITS digits are held. `digit_count` increments, saturating.
- **States:** IDLE, ENTRY, LOAD, RUN.
  - **IDLE:** a valid digit is shifted in and the state moves to ENTRY. `start` is ignored.
  - **ENTRY:** a valid digit is shifted in and the state stays in ENTRY. `start` moves to LOAD; any digit in the same cycle is discarded. `clear` moves to IDLE and zeroes `digits` and `digit_count`.
  - **LOAD:** `loadn`=0 for LOAD_PULSE cycles, then the state moves to RUN. `digits` is held stable. Keys, `start` and `clear` are ignored.
  - **RUN:** `enablen`=1 and keys are ignored. `timer_done` or `clear` moves to IDLE and zeroes `digits` and `digit_count`.
- **Priority in any one cycle:** `clear` > `timer_done` > `start` > key.
- **`enablen`:** 1 only in RUN; 0 in all other states.

## Timing
- **Reset values:**
  - State IDLE.
  - `digits`=0, `digit_count`=0.
  - `loadn`=1, `enablen`=0.
  - `vd_q`=1, so a key held through reset release is not captured.
- **Digit latency:** a key sampled at edge N is visible on `digits` and `digit_count` after edge N.
- **Load latency:** `start` sampled in ENTRY at edge N gives `loadn`=0 after edge N+1 (LOAD entry), held for LOAD_PULSE cycles.
- **Run entry:** `enablen` rises the same edge that `loadn` returns to 1.
- **Return to entry:** after `timer_done` or `clear` in RUN, `enablen` returns to 0 one edge later.
- **Reset mid-LOAD:** `loadn` returns to 1 immediately (asynchronous); no partial-pulse recovery.

## Configuration
- **`TIMER_ENTRY_SEC_CLAMP_EN` defined:** on the ENTRY→LOAD transition, if `digits[7:0]` > 0x59 (seconds tens > 5, or the value is otherwise above 59), `digits[7:0]` is forced to 0x59. The clamped value is what `loadn` presents.
- **`TIMER_ENTRY_SEC_CLAMP_EN` undefined:** `digits` passes unchanged.

## Test plan
- **Digit entry:** reset, then key presses 1, 2, 3, 0, each held 5 cycles → `digits`=0x1230, `digit_count`=4, one shift per press.
- **Overflow:** a 5th press, 7 → `digits`=0x2307, `digit_count`=4.
- **Load and run:**
  - Enter 0x0130, then `start` for 1 cycle → `loadn` low exactly LOAD_PULSE cycles, then `enablen`=1.
  - Key presses while `enablen`=1 leave `digits` unchanged.
  - `timer_done` → IDLE, `digits`=0, `enablen`=0.
- **Simultaneous events:**
  - `start` and a key edge in the same cycle in ENTRY → LOAD, digit dropped.
  - `clear` and `start` together → IDLE, `digits`=0.
  - `start` in IDLE → no `loadn`.
- **Reset and invalid digit:**
  - `valid_data` held high across `rst_n` release → no capture.
  - `bcd`=0xC with `valid_data` → ignored.
  - `rst_n` low during LOAD → `loadn`=1 immediately.
- **Clamp:** enter 0x0175, then `start` → `digits`=0x0159 during `loadn` with the macro defined; 0x0175 without it.
